nios2_pio_in_irq: RTL and testbench

Parametrised Avalon-MM input PIO, the successor to the fixed 10-bit switch port. It synchronises and optionally debounces WIDTH asynchronous inputs such as switches and keys. It latches selected edges into a sticky capture register and raises a maskable level interrupt to the Nios II. It sits on the system interconnect as a slave with read latency 1.

---
 rtl/nios2_pio_pkg.sv | 30 +++
 rtl/nios2_pio_in_debounce.sv | 76 +++++++
 rtl/nios2_pio_in_irq.sv | 141 ++++++++++++++
 tb/tb_nios2_pio_in_irq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/nios2_pio_pkg.sv
// ---------------------------------------------------------------------------
// nios2_pio_pkg
// Shared definitions for the Nios II input PIO slice.
//   - Avalon-MM register word addresses
//   - EDGE_TYPE encodings for the edge-capture selector
//   - pio_edge_bit(): picks the edge event of one bit for a given EDGE_TYPE
// ---------------------------------------------------------------------------
package nios2_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Unknown encodings fall back to rising-edge capture.
    function automatic logic pio_edge_bit(input logic rise,
                                          input logic fall,
                                          input int   edge_type);
        case (edge_type)
            EDGE_FALL: return fall;
            EDGE_ANY:  return rise | fall;
            default:   return rise;
        endcase
    endfunction

endpackage

// File: rtl/nios2_pio_in_debounce.sv
// ---------------------------------------------------------------------------
// nios2_pio_in_debounce
// Per-bit debouncer for the input PIO. A bit only adopts a new level after the
// synchronised input has differed from the current stable level for
// DEBOUNCE_CYCLES consecutive clocks; any return to the stable level restarts
// the count. DEBOUNCE_CYCLES = 0 turns the block into a wire.
//
// Ports:
//   clk      in   1      system clock
//   reset_n  in   1      asynchronous active-low reset
//   synced   in   WIDTH  synchronised input levels
//   stable   out  WIDTH  debounced levels
// ---------------------------------------------------------------------------
module nios2_pio_in_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] synced,
    output logic [WIDTH-1:0] stable
);

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass

            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ reset_n;
            assign stable = synced;

        end else begin : g_debounce

            localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] cnt_q [WIDTH];
            logic [CNT_W-1:0] cnt_d [WIDTH];
            logic [WIDTH-1:0] stable_q;
            logic [WIDTH-1:0] stable_d;

            // The count reaching CNT_LAST while still differing means this
            // edge is the DEBOUNCE_CYCLES-th consecutive differing sample.
            always_comb begin
                stable_d = stable_q;
                for (int i = 0; i < WIDTH; i++) begin
                    cnt_d[i] = '0;
                    if (synced[i] != stable_q[i]) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            stable_d[i] = synced[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    stable_q <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    stable_q <= stable_d;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign stable = stable_q;

        end
    endgenerate

endmodule

// File: rtl/nios2_pio_in_irq.sv
// ---------------------------------------------------------------------------
// nios2_pio_in_irq
// Avalon-MM input PIO with edge capture and maskable level interrupt.
// Inputs pass through a SYNC_STAGES flop synchroniser, an optional debouncer,
// and an edge detector feeding a sticky EDGECAPTURE register.
//
// Register map (word addresses):
//   0 DATA        RO  debounced input level
//   1 -           reads 0, writes ignored
//   2 IRQMASK     RW  interrupt enable per bit
//   3 EDGECAPTURE R/W1C sticky edge flags
//
// Ports:
//   clk         in   1      system clock
//   reset_n     in   1      asynchronous active-low reset
//   address     in   2      register word select
//   chipselect  in   1      slave select (qualifies writes)
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data (only [WIDTH-1:0] used)
//   in_port     in   WIDTH  asynchronous external inputs
//   readdata    out  32     registered read data, zero-extended, latency 1
//   irq         out  1      level interrupt, active-high
// ---------------------------------------------------------------------------
module nios2_pio_in_irq
    import nios2_pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] irqmask_d;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] edgecap_d;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      readdata_q;
    logic [31:0]      readdata_d;
    logic             wr_en;

    // Upper writedata bits are architecturally ignored.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Plain shift chain: nothing may sit between synchroniser stages.
    always_comb begin
        sync_d[0] = in_port;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    nios2_pio_in_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_n (reset_n),
        .synced  (synced),
        .stable  (stable)
    );

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        prev_d = stable;
        for (int i = 0; i < WIDTH; i++) begin
            edge_det[i] = pio_edge_bit(stable[i] & ~prev_q[i],
                                       ~stable[i] & prev_q[i],
                                       EDGE_TYPE);
        end
    end

    // A new edge wins over a same-cycle write-1-to-clear so no event is lost.
    always_comb begin
        irqmask_d  = irqmask_q;
        clear_bits = '0;
        if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && (address == PIO_ADDR_EDGECAP)) begin
            clear_bits = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clear_bits) | edge_det;
    end

    // Read mux is sampled every clock regardless of chipselect.
    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = stable;
            PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
            PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
            default:          readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            prev_q     <= prev_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_nios2_pio_in_irq.sv
// ---------------------------------------------------------------------------
// tb_nios2_pio_in_irq
// Directed bench for nios2_pio_in_irq. Three instances share the Avalon bus:
//   dut0   defaults (rising edge, no debounce)
//   dutDb  DEBOUNCE_CYCLES = 4
//   dutFl  EDGE_TYPE = 1 (falling edge)
// ---------------------------------------------------------------------------
module tb_nios2_pio_in_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [9:0]  inPort0, inPort1, inPort2;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checkCount;
    int passCount;

    nios2_pio_in_irq dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(inPort0),
        .readdata(rd0), .irq(irq0)
    );

    nios2_pio_in_irq #(.DEBOUNCE_CYCLES(4)) dutDb (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(inPort1),
        .readdata(rd1), .irq(irq1)
    );

    nios2_pio_in_irq #(.EDGE_TYPE(1)) dutFl (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(inPort2),
        .readdata(rd2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 32'h%08h, expected 32'h%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b,
                                 input logic [9:0] c);
        inPort0 = a;
        inPort1 = b;
        inPort2 = c;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic busRead(input logic [1:0] a);
        address = a;
        tick(1);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        applyStimulus(10'h3FF, 10'h000, 10'h000);

        tick(2);
        checkOutput("reset_rd0", rd0, 32'h0);
        checkOutput("reset_irq0", {31'b0, irq0}, 32'h0);
        checkOutput("reset_rd1", rd1, 32'h0);

        // Post-reset rising edge on all-high inputs
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(2);
        checkOutput("data_latency_early", rd0, 32'h0);
        tick(1);
        checkOutput("data_post_reset", rd0, 32'h000003FF);
        busRead(2'd3);
        checkOutput("edgecap_post_reset", rd0, 32'h000003FF);

        // Quiet the inputs, clear captures, enable bit0
        applyStimulus(10'h000, 10'h000, 10'h000);
        tick(4);
        busWrite(2'd3, 32'h000003FF);
        busWrite(2'd2, 32'h00000001);
        busRead(2'd3);
        checkOutput("edgecap_cleared", rd0, 32'h0);

        // bit0 rising edge: irq exactly two edges after sampling
        applyStimulus(10'h001, 10'h000, 10'h000);
        tick(1);
        checkOutput("irq_k", {31'b0, irq0}, 32'h0);
        tick(1);
        checkOutput("irq_k1", {31'b0, irq0}, 32'h0);
        tick(1);
        checkOutput("irq_k2", {31'b0, irq0}, 32'h1);
        tick(1);
        checkOutput("edgecap_bit0", rd0, 32'h00000001);

        // Reserved address: reads zero, writes have no effect
        busWrite(2'd1, 32'hFFFFFFFF);
        busRead(2'd1);
        checkOutput("rsvd_read", rd0, 32'h0);
        busRead(2'd2);
        checkOutput("mask_unchanged", rd0, 32'h00000001);
        busRead(2'd3);
        checkOutput("edgecap_unchanged", rd0, 32'h00000001);
        checkOutput("irq_still_high", {31'b0, irq0}, 32'h1);

        // Write-1-to-clear drops irq the next cycle
        busWrite(2'd3, 32'h00000001);
        checkOutput("irq_after_clear", {31'b0, irq0}, 32'h0);

        // bit5 edge coinciding with its clear write: set wins
        applyStimulus(10'h021, 10'h000, 10'h000);
        tick(2);
        busWrite(2'd3, 32'h00000020);
        busRead(2'd3);
        checkOutput("set_over_clear", rd0, 32'h00000020);

        // Debounce: 3-cycle pulse rejected
        applyStimulus(10'h021, 10'h008, 10'h000);
        tick(3);
        applyStimulus(10'h021, 10'h000, 10'h000);
        tick(8);
        busRead(2'd0);
        checkOutput("db_glitch_data", rd1, 32'h0);
        busRead(2'd3);
        checkOutput("db_glitch_edgecap", rd1, 32'h0);

        // Debounce: held level accepted at k+6
        busRead(2'd0);
        applyStimulus(10'h021, 10'h008, 10'h000);
        tick(6);
        checkOutput("db_data_k5", rd1, 32'h0);
        tick(1);
        checkOutput("db_data_k6", rd1, 32'h00000008);
        busRead(2'd3);
        checkOutput("db_edgecap", rd1, 32'h00000008);

        // Falling-edge instance: rise ignored, fall captured, irq via mask bit2
        busWrite(2'd2, 32'h00000005);
        applyStimulus(10'h021, 10'h008, 10'h004);
        tick(4);
        busRead(2'd3);
        checkOutput("fall_rise_ignored", rd2, 32'h0);
        checkOutput("fall_irq_idle", {31'b0, irq2}, 32'h0);
        applyStimulus(10'h021, 10'h008, 10'h000);
        tick(2);
        checkOutput("fall_irq_early", {31'b0, irq2}, 32'h0);
        tick(1);
        checkOutput("fall_irq", {31'b0, irq2}, 32'h1);
        busRead(2'd3);
        checkOutput("fall_edgecap", rd2, 32'h00000004);
        checkOutput("irq0_masked", {31'b0, irq0}, 32'h0);
        busWrite(2'd2, 32'h00000000);
        checkOutput("fall_irq_unmasked", {31'b0, irq2}, 32'h0);

        // Reset in the middle of a debounce count
        busRead(2'd0);
        checkOutput("pre_reset_rd1", rd1, 32'h00000008);
        applyStimulus(10'h000, 10'h000, 10'h000);
        tick(3);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_rd0", rd0, 32'h0);
        checkOutput("async_reset_rd1", rd1, 32'h0);
        checkOutput("async_reset_rd2", rd2, 32'h0);
        checkOutput("async_reset_irq", {29'b0, irq0, irq1, irq2}, 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick(8);
        busRead(2'd3);
        checkOutput("no_capture_carry", rd1, 32'h0);
        busRead(2'd0);
        checkOutput("no_debounce_carry", rd1, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
